// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and helpers for the round-robin register write arbiter.
// Holds the FSM state encoding and a constant-safe ceiling log2.
package reg_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) r++;
    return r;
  endfunction

  localparam int NREQ_DEF  = 4;
  localparam int IDX_W_DEF = clog2(NREQ_DEF);

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Bus between the requesters and the write arbiter: requests, data, grant and register view.
// A requester holds req (and lock) level; its wdata slice is captured on the edge where its gnt is high.
interface reg_write_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 8
);
  import reg_arb_pkg::*;

  localparam int IDX_W = clog2(NREQ);

  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        lock;
  logic [NREQ*DATA_W-1:0] wdata;
  logic [NREQ-1:0]        gnt;
  logic [DATA_W-1:0]      q;
  logic                   q_vld;
  logic [IDX_W-1:0]       q_src;
  logic                   busy;
  arb_state_e             state;

  modport master (
    output req, lock, wdata,
    input  gnt, q, q_vld, q_src, busy, state
  );

  modport slave (
    input  req, lock, wdata,
    output gnt, q, q_vld, q_src, busy, state
  );

endinterface

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo NREQ.
// Rotates the request vector by ptr, priority-encodes, then maps the position back.
module rr_pick
  import reg_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [NREQ-1:0]  onehot_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [NREQ-1:0] rot;
  logic            found;

  always_comb begin
    rot      = '0;
    found    = 1'b0;
    idx_o    = '0;
    onehot_o = '0;
    for (int k = 0; k < NREQ; k++) begin
      rot[k] = req_i[(int'(ptr_i) + k) % NREQ];
    end
    for (int k = 0; k < NREQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        idx_o = IDX_W'((int'(ptr_i) + k) % NREQ);
      end
    end
    if (found) onehot_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Shared 8-bit capture register with round-robin arbitration and bounded locked bursts.
// IDLE arbitrates among all requesters; OWN serves only the locked owner until it releases.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               reset,
  reg_write_arbiter_if.slave bus
);

  localparam int IDX_W = clog2(NREQ);
  localparam int CNT_W = clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  arb_state_e        state_q;
  logic [IDX_W-1:0]  rr_ptr_q;
  logic [CNT_W-1:0]  burst_cnt_q;
  logic [DATA_W-1:0] q_q;
  logic              q_vld_q;
  logic [IDX_W-1:0]  q_src_q;

  logic [NREQ-1:0]   pick_onehot;
  logic [IDX_W-1:0]  pick_idx;
  logic [NREQ-1:0]   gnt_c;
  logic [IDX_W-1:0]  win_idx;
  logic              do_write;
  logic              last_write;

  function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + IDX_ONE;
  endfunction

  rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
    .req_i   (bus.req),
    .ptr_i   (rr_ptr_q),
    .onehot_o(pick_onehot),
    .idx_o   (pick_idx)
  );

  // In OWN the owner keeps the grant only while its burst budget is not used up.
  always_comb begin
    gnt_c   = '0;
    win_idx = pick_idx;
    if (!reset) begin
      if (state_q == IDLE) begin
        gnt_c = pick_onehot;
      end else begin
        win_idx = q_src_q;
        if (bus.req[q_src_q] && (burst_cnt_q < MAX_CNT)) gnt_c[q_src_q] = 1'b1;
      end
    end
  end

  assign do_write   = |gnt_c;
  assign last_write = (burst_cnt_q + CNT_ONE) >= MAX_CNT;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      q_q         <= '0;
      q_vld_q     <= 1'b0;
      q_src_q     <= '0;
    end else begin
      q_vld_q <= do_write;
      if (do_write) begin
        q_q     <= bus.wdata[int'(win_idx)*DATA_W +: DATA_W];
        q_src_q <= win_idx;
      end
      case (state_q)
        IDLE: begin
          if (do_write) begin
            if (bus.lock[win_idx]) begin
              state_q     <= OWN;
              burst_cnt_q <= CNT_ONE;
            end else begin
              rr_ptr_q <= ptr_inc(win_idx);
            end
          end
        end
        OWN: begin
          // The write that fills the budget also releases, so the next cycle re-arbitrates.
          if (!do_write || !bus.lock[q_src_q] || last_write) begin
            state_q     <= IDLE;
            burst_cnt_q <= '0;
            rr_ptr_q    <= ptr_inc(q_src_q);
          end else begin
            burst_cnt_q <= burst_cnt_q + CNT_ONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt   = gnt_c;
  assign bus.q     = q_q;
  assign bus.q_vld = q_vld_q;
  assign bus.q_src = q_src_q;
  assign bus.busy  = (state_q == OWN);
  assign bus.state = state_q;

endmodule
